// File: rtl/ripple_pkg.sv
// Shared constants and helpers for the segmented, pipelined ripple-carry adder.
package ripple_pkg;

    localparam int SEG_DEFAULT = 4;

    function automatic int stages(input int n, input int seg);
        return n / seg;
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell; the unit the ripple segments are chained from.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/ripple_segment.sv
// Combinational SEG-bit ripple adder; also exposes the carry into its top bit
// so the final segment can derive signed overflow.
module ripple_segment
    import ripple_pkg::*;
#(
    parameter int SEG = SEG_DEFAULT
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] sum,
    output logic           co,
    output logic           c_msb_in
);

    logic [SEG:0] carry;

    assign carry[0] = ci;

    for (genvar gi = 0; gi < SEG; gi++) begin : g_bit
        full_adder u_fa (
            .a  (a[gi]),
            .b  (b[gi]),
            .ci (carry[gi]),
            .s  (sum[gi]),
            .co (carry[gi+1])
        );
    end

    assign co       = carry[SEG];
    assign c_msb_in = carry[SEG-1];

endmodule

// File: rtl/pipelined_ripple_adder.sv
// N-bit add/subtract split into SEG-bit ripple segments, one register stage per
// segment, with a single global advance enable driven by output backpressure.
module pipelined_ripple_adder
    import ripple_pkg::*;
#(
    parameter int N   = 24,
    parameter int SEG = SEG_DEFAULT
) (
    input  logic         ck,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         ci,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] SUM,
    output logic         co,
    output logic         ovf
);

    localparam int STAGES = stages(N, SEG);
    localparam int LAST   = STAGES - 1;

    if ((SEG < 1) || (N % SEG != 0)) begin : g_bad_config
        $error("pipelined_ripple_adder: N must be a positive multiple of SEG");
    end

    // Whole-width fields keep indexing uniform; each stage only owns one slice
    // of sum and only consumes one slice of the a/b skew copies.
    typedef struct packed {
        logic         valid;
        logic [N-1:0] sum;
        logic         carry;
        logic         ovf;
        logic [N-1:0] a;
        logic [N-1:0] b;
    } stage_t;

    stage_t stage_q [STAGES];
    stage_t head;
    logic   en;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Subtraction is A + ~B + 1, with the borrow-in folded into the carry-in.
    assign head = '{
        valid: in_valid,
        sum:   '0,
        carry: ci ^ sub,
        ovf:   1'b0,
        a:     A,
        b:     sub ? ~B : B
    };

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        stage_t         prev;
        stage_t         rec_next;
        stage_t         rec_reg;
        logic [SEG-1:0] seg_sum;
        logic           seg_co;
        logic           seg_c_msb;

        if (gi == 0) begin : g_head
            assign prev = head;
        end else begin : g_tail
            assign prev = stage_q[gi-1];
        end

        ripple_segment #(.SEG(SEG)) u_seg (
            .a        (prev.a[gi*SEG +: SEG]),
            .b        (prev.b[gi*SEG +: SEG]),
            .ci       (prev.carry),
            .sum      (seg_sum),
            .co       (seg_co),
            .c_msb_in (seg_c_msb)
        );

        always_comb begin
            rec_next                     = prev;
            rec_next.sum[gi*SEG +: SEG]  = seg_sum;
            rec_next.carry               = seg_co;
            rec_next.ovf                 = seg_c_msb ^ seg_co;
        end

        always_ff @(posedge ck or posedge rst) begin
            if (rst) begin
                rec_reg <= '0;
            end else if (en) begin
                rec_reg <= rec_next;
            end
        end

        assign stage_q[gi] = rec_reg;
    end

    assign out_valid = stage_q[LAST].valid;
    assign SUM       = stage_q[LAST].sum;
    assign co        = stage_q[LAST].carry;
    assign ovf       = stage_q[LAST].ovf;

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Scoreboard bench: expected results are queued on acceptance and compared in
// order as the adder emits them, under both free-flowing and stalled outputs.
module tb_pipelined_ripple_adder;

    localparam int N      = 24;
    localparam int SEG    = 4;
    localparam int STAGES = N / SEG;

    typedef struct {
        logic [N-1:0] sum;
        logic         co;
        logic         ovf;
        int           acc_cyc;
    } exp_t;

    logic         ck = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         ci;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] SUM;
    logic         co;
    logic         ovf;

    logic         in_valid8;
    logic         in_ready8;
    logic [7:0]   a8;
    logic [7:0]   b8;
    logic         ci8;
    logic         sub8;
    logic         out_valid8;
    logic         out_ready8;
    logic [7:0]   sum8;
    logic         co8;
    logic         ovf8;

    int   tests_run    = 0;
    int   tests_failed = 0;
    int   cyc          = 0;
    int   nbeats       = 0;
    int   rdy_mode     = 0;
    logic check_lat    = 1'b0;
    exp_t q[$];

    always #5 ck = ~ck;

    pipelined_ripple_adder #(.N(N), .SEG(SEG)) dut (
        .ck        (ck),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .ci        (ci),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .SUM       (SUM),
        .co        (co),
        .ovf       (ovf)
    );

    pipelined_ripple_adder #(.N(8), .SEG(8)) dut8 (
        .ck        (ck),
        .rst       (rst),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .A         (a8),
        .B         (b8),
        .ci        (ci8),
        .sub       (sub8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .SUM       (sum8),
        .co        (co8),
        .ovf       (ovf8)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                   input logic c, input logic s);
        exp_t         e;
        logic [N-1:0] be;
        logic [N:0]   full;
        be = s ? ~b : b;
        if (!s) begin
            full = {1'b0, a} + {1'b0, b} + (N+1)'(c);
            e.co = full[N];
        end else begin
            full = {1'b0, a} - {1'b0, b} - (N+1)'(c);
            e.co = ({1'b0, a} >= ({1'b0, b} + (N+1)'(c)));
        end
        e.sum     = full[N-1:0];
        e.ovf     = (a[N-1] == be[N-1]) && (e.sum[N-1] != a[N-1]);
        e.acc_cyc = 0;
        return e;
    endfunction

    initial begin
        forever begin
            @(posedge ck);
            cyc++;
        end
    end

    // Consumer: always ready, or random with occasional 10-cycle stalls.
    initial begin
        int low_run = 0;
        int r;
        forever begin
            @(posedge ck);
            #1;
            if (rdy_mode == 0) begin
                out_ready = 1'b1;
                low_run   = 0;
            end else if (low_run > 0) begin
                out_ready = 1'b0;
                low_run--;
            end else begin
                r = $urandom_range(0, 19);
                if (r == 0) begin
                    low_run   = 9;
                    out_ready = 1'b0;
                end else begin
                    out_ready = r[0];
                end
            end
        end
    end

    // Monitor: pushes on acceptance, pops and compares on output transfer.
    initial begin
        logic         hold_valid = 1'b0;
        logic [N-1:0] held_sum   = '0;
        logic         held_co    = 1'b0;
        logic         held_ovf   = 1'b0;
        exp_t         e;
        forever begin
            @(negedge ck);
            if (rst) begin
                hold_valid = 1'b0;
            end else begin
                if (hold_valid && out_valid) begin
                    check_val("stall_sum", 32'(SUM), 32'(held_sum));
                    check_val("stall_co", 32'(co), 32'(held_co));
                    check_val("stall_ovf", 32'(ovf), 32'(held_ovf));
                end
                if (out_valid && out_ready) begin
                    check_val("queue_nonempty", 32'(q.size() != 0), 32'd1);
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        nbeats++;
                        $display("[TB] beat %0d out SUM=%h co=%b ovf=%b exp SUM=%h co=%b ovf=%b",
                                 nbeats, SUM, co, ovf, e.sum, e.co, e.ovf);
                        check_val("sum", 32'(SUM), 32'(e.sum));
                        check_val("co", 32'(co), 32'(e.co));
                        check_val("ovf", 32'(ovf), 32'(e.ovf));
                        if (check_lat) begin
                            check_val("latency", 32'(cyc - e.acc_cyc), 32'(STAGES));
                        end
                    end
                end
                hold_valid = out_valid && !out_ready;
                held_sum   = SUM;
                held_co    = co;
                held_ovf   = ovf;
                if (in_valid && in_ready) begin
                    e         = model(A, B, ci, sub);
                    e.acc_cyc = cyc;
                    q.push_back(e);
                end
            end
        end
    end

    // Present one beat and hold it until accepted; returns just after the accepting edge.
    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic c, input logic s);
        int   tries = 0;
        logic acc;
        A        = a;
        B        = b;
        ci       = c;
        sub      = s;
        in_valid = 1'b1;
        do begin
            @(negedge ck);
            acc = in_ready;
            @(posedge ck);
            #1;
            tries++;
        end while (!acc && tries < 1000);
        if (!acc) check_val("send_timeout", 32'(acc), 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        in_valid = 1'b0;
        while ((q.size() != 0 || out_valid) && n < 2000) begin
            @(posedge ck);
            #2;
            n++;
        end
        check_val("drain", 32'(q.size()), 32'd0);
    endtask

    initial begin
        rst        = 1'b0;
        in_valid   = 1'b0;
        A          = '0;
        B          = '0;
        ci         = 1'b0;
        sub        = 1'b0;
        out_ready  = 1'b1;
        in_valid8  = 1'b0;
        a8         = '0;
        b8         = '0;
        ci8        = 1'b0;
        sub8       = 1'b0;
        out_ready8 = 1'b1;
        #1;
        rst      = 1'b1;
        in_valid = 1'b1;
        A        = 24'hFFFFFF;
        B        = 24'h000001;
        for (int i = 0; i < 3; i++) begin
            @(negedge ck);
            check_val("rst_out_valid", 32'(out_valid), 32'd0);
            check_val("rst_sum", 32'(SUM), 32'd0);
            check_val("rst_co", 32'(co), 32'd0);
            check_val("rst_ovf", 32'(ovf), 32'd0);
        end
        @(posedge ck);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge ck);
        check_val("in_ready_after_rst", 32'(in_ready), 32'd1);
        @(posedge ck);
        #1;

        check_lat = 1'b1;
        send(24'hFFFFFF, 24'h000001, 1'b0, 1'b0);
        wait_idle();
        send(24'h000005, 24'h000007, 1'b0, 1'b1);
        send(24'h800000, 24'h000001, 1'b0, 1'b1);
        wait_idle();

        check_lat = 1'b0;
        rdy_mode  = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge ck);
                #1;
            end
            send(24'($urandom), 24'($urandom), 1'($urandom), 1'($urandom));
        end
        wait_idle();
        rdy_mode = 0;
        @(posedge ck);
        #1;

        // Three beats in flight, then a one-cycle reset must discard all of them.
        send(24'h111111, 24'h222222, 1'b0, 1'b0);
        send(24'h333333, 24'h444444, 1'b1, 1'b0);
        send(24'h555555, 24'h000001, 1'b0, 1'b1);
        in_valid = 1'b0;
        rst      = 1'b1;
        q.delete();
        @(posedge ck);
        #1;
        rst       = 1'b0;
        check_lat = 1'b1;
        send(24'h123456, 24'h654321, 1'b1, 1'b0);
        wait_idle();
        repeat (10) @(posedge ck);
        #1;

        a8        = 8'h7F;
        b8        = 8'h01;
        ci8       = 1'b0;
        sub8      = 1'b0;
        in_valid8 = 1'b1;
        @(negedge ck);
        check_val("n8_valid_before", 32'(out_valid8), 32'd0);
        check_val("n8_in_ready", 32'(in_ready8), 32'd1);
        @(posedge ck);
        #1;
        in_valid8 = 1'b0;
        @(negedge ck);
        check_val("n8_valid_lat1", 32'(out_valid8), 32'd1);
        check_val("n8_sum", 32'(sum8), 32'h80);
        check_val("n8_ovf", 32'(ovf8), 32'd1);
        check_val("n8_co", 32'(co8), 32'd0);
        @(negedge ck);
        check_val("n8_valid_after", 32'(out_valid8), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
